// File: rtl/iod_delay_line_sequencer_if.sv
// Requester-side bundle of the IOD delay-line sequencer: per-requester commands,
// grant vector and completion report.
interface iod_delay_line_sequencer_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [2*NUM_REQ-1:0] req_op;
    logic [8*NUM_REQ-1:0] req_steps;
    logic [NUM_REQ-1:0]   done;
    logic                 done_err;

    modport master (
        output req_valid, req_op, req_steps,
        input  req_ready, done, done_err
    );

    modport slave (
        input  req_valid, req_op, req_steps,
        output req_ready, done, done_err
    );
endinterface

// File: rtl/iod_delay_line_sequencer.sv
// Round-robin arbiter and pulse sequencer for one DDR4 PHY lane IOD delay line:
// turns LOAD / INC / DEC commands into spaced LOAD/MOVE pulses and tracks the tap.
module iod_delay_line_sequencer #(
    parameter int NUM_REQ   = 2,
    parameter int TAP_MAX   = 127,
    parameter int RESET_TAP = 1,
    parameter int MOVE_GAP  = 3
) (
    input  logic                      fab_clk,
    input  logic                      dly_sync_rst,
    iod_delay_line_sequencer_if.slave req,
    output logic                      busy,
    output logic [7:0]                tap_pos,
    output logic                      delay_line_move,
    output logic                      delay_line_direction,
    output logic                      delay_line_load,
    input  logic                      delay_line_out_of_range
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] OP_NOP  = 2'd0;
    localparam logic [1:0] OP_LOAD = 2'd1;
    localparam logic [1:0] OP_INC  = 2'd2;
    localparam logic [1:0] OP_DEC  = 2'd3;

    localparam logic [7:0] TAP_MAX_V   = 8'(TAP_MAX);
    localparam logic [7:0] RESET_TAP_V = 8'(RESET_TAP);
    localparam logic [3:0] GAP_LAST    = 4'(MOVE_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_MOVE, S_LOAD, S_GAP, S_RESP
    } state_t;

    state_t state_reg, state_next;

    logic [7:0]       tap_pos_reg;
    logic [IDX_W-1:0] last_grant_reg;
    logic [IDX_W-1:0] owner_reg;
    logic [1:0]       op_reg;
    logic [7:0]       remaining_reg;
    logic [3:0]       gap_cnt_reg;
    logic             err_reg;
    logic             direction_reg;

    logic [1:0]       op_arr    [NUM_REQ];
    logic [7:0]       steps_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_arr[gi]    = req.req_op[2*gi +: 2];
            assign steps_arr[gi] = req.req_steps[8*gi +: 8];
        end
    endgenerate

    // Round-robin scan starting just after the previous winner.
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;

    always_comb begin
        int cand;
        cand        = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_grant_reg) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!grant_valid && req.req_valid[IDX_W'(cand)]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    logic [1:0] acc_op;
    logic [7:0] acc_steps;
    logic       acc_move;
    logic       range_block;
    logic       gap_last;

    assign acc_op      = op_arr[grant_idx];
    assign acc_steps   = steps_arr[grant_idx];
    assign acc_move    = (acc_op == OP_INC || acc_op == OP_DEC) && (acc_steps != 8'd0);
    // Refuse the next step if it would leave the legal tap range.
    assign range_block = ((op_reg == OP_INC) && (tap_pos_reg == TAP_MAX_V)) ||
                         ((op_reg == OP_DEC) && (tap_pos_reg == 8'd0));
    assign gap_last    = (gap_cnt_reg == 4'd0);

    always_ff @(posedge fab_clk) begin
        if (dly_sync_rst) state_reg <= S_IDLE;
        else              state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (grant_valid) begin
                    if (acc_op == OP_LOAD) state_next = S_LOAD;
                    else if (acc_move)     state_next = S_SETUP;
                    else                   state_next = S_RESP;
                end
            end
            S_SETUP: state_next = range_block ? S_RESP : S_MOVE;
            S_MOVE:  state_next = S_GAP;
            S_LOAD:  state_next = S_GAP;
            S_GAP: begin
                if (gap_last) begin
                    if (delay_line_out_of_range)     state_next = S_RESP;
                    else if (remaining_reg != 8'd0)  state_next = S_SETUP;
                    else                             state_next = S_RESP;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    logic [NUM_REQ-1:0] ready_vec;
    logic [NUM_REQ-1:0] done_vec;
    logic               done_err_bit;

    always_comb begin
        ready_vec       = '0;
        done_vec        = '0;
        done_err_bit    = 1'b0;
        busy            = (state_reg != S_IDLE);
        delay_line_move = (state_reg == S_MOVE);
        delay_line_load = (state_reg == S_LOAD);
        if (state_reg == S_IDLE && grant_valid) ready_vec[grant_idx] = 1'b1;
        if (state_reg == S_RESP) begin
            done_vec[owner_reg] = 1'b1;
            done_err_bit        = err_reg;
        end
    end

    assign req.req_ready        = ready_vec;
    assign req.done             = done_vec;
    assign req.done_err         = done_err_bit;
    assign tap_pos              = tap_pos_reg;
    assign delay_line_direction = direction_reg;

    always_ff @(posedge fab_clk) begin
        if (dly_sync_rst) begin
            tap_pos_reg    <= RESET_TAP_V;
            last_grant_reg <= IDX_W'(NUM_REQ - 1);
            owner_reg      <= '0;
            op_reg         <= OP_NOP;
            remaining_reg  <= 8'd0;
            gap_cnt_reg    <= 4'd0;
            err_reg        <= 1'b0;
            direction_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (grant_valid) begin
                        owner_reg      <= grant_idx;
                        last_grant_reg <= grant_idx;
                        op_reg         <= acc_op;
                        err_reg        <= 1'b0;
                        // LOAD carries no steps so its GAP always ends in RESP.
                        remaining_reg  <= acc_move ? acc_steps : 8'd0;
                        if (acc_move) direction_reg <= (acc_op == OP_INC);
                    end
                end
                S_SETUP: begin
                    if (range_block) err_reg <= 1'b1;
                end
                S_MOVE: begin
                    tap_pos_reg   <= direction_reg ? tap_pos_reg + 8'd1 : tap_pos_reg - 8'd1;
                    remaining_reg <= remaining_reg - 8'd1;
                    gap_cnt_reg   <= GAP_LAST;
                end
                S_LOAD: begin
                    tap_pos_reg <= RESET_TAP_V;
                    gap_cnt_reg <= GAP_LAST;
                end
                S_GAP: begin
                    if (!gap_last)                    gap_cnt_reg <= gap_cnt_reg - 4'd1;
                    else if (delay_line_out_of_range) err_reg     <= 1'b1;
                end
                S_RESP: err_reg <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
